// File: rtl/dram_word_bridge.sv
// dram_word_bridge
// Turns single 32-bit core memory requests into 128-bit DRAM line commands.
// A one-line read buffer serves repeated word reads within a 16-byte line
// without touching DRAM. Writes always go through to DRAM as masked line
// writes. If a write lands in the buffered line, the buffer is updated too.
// Only one request is in flight at a time, and every output is a flop.
module dram_word_bridge #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wen,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [3:0]                req_wstrb,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,

  output logic                      dram_ren,
  output logic                      dram_wen,
  output logic [APP_ADDR_WIDTH-2:0] dram_addr,
  output logic [APP_DATA_WIDTH-1:0] dram_wdata,
  output logic [APP_MASK_WIDTH-1:0] dram_wmask,
  input  logic                      dram_init_calib_complete,
  input  logic                      dram_busy,
  input  logic [APP_DATA_WIDTH-1:0] dram_rdata,
  input  logic                      dram_rdata_valid
);

  localparam int DRAM_AW = APP_ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    WR_CMD,
    RESP
  } state_t;

  state_t state_q;
  state_t state_n;

  // The address is split into a line tag and a word lane. The top nibble and
  // the byte offset carry no information, so the space aliases every 256 MiB.
  logic [23:0]        req_tag;
  logic [1:0]         req_lane;
  logic [DRAM_AW-1:0] req_line_addr;
  logic               unused_addr_bits;

  assign req_tag          = req_addr[27:4];
  assign req_lane         = req_addr[3:2];
  assign req_line_addr    = DRAM_AW'({req_tag, 3'b000});
  assign unused_addr_bits = ^{req_addr[31:28], req_addr[1:0]};

  // The line buffer holds the most recently fetched line.
  logic                      buf_valid;
  logic [23:0]               buf_tag;
  logic [APP_DATA_WIDTH-1:0] buf_data;
  logic [APP_DATA_WIDTH-1:0] buf_merged;

  // These registers remember the outstanding miss, so the returned line can
  // be tagged and the requested word picked out of it.
  logic [23:0] lat_tag;
  logic [1:0]  lat_lane;

  logic req_fire;
  logic buf_hit;

  assign req_fire = req_valid && req_ready;
  assign buf_hit  = buf_valid && (buf_tag == req_tag);

  // Next values for the registered outputs.
  logic                      req_ready_n;
  logic                      resp_valid_n;
  logic [31:0]               resp_rdata_n;
  logic                      dram_ren_n;
  logic                      dram_wen_n;
  logic [DRAM_AW-1:0]        dram_addr_n;
  logic [APP_DATA_WIDTH-1:0] dram_wdata_n;
  logic [APP_MASK_WIDTH-1:0] dram_wmask_n;

  // Build a copy of the buffered line with the write's strobed bytes merged into the addressed lane.
  always_comb begin
    buf_merged = buf_data;
    for (int b = 0; b < 4; b++) begin
      if (req_wstrb[b]) begin
        buf_merged[{req_lane, 5'b00000} + 7'(8 * b) +: 8] = req_wdata[8 * b +: 8];
      end
    end
  end

  // Compute the next state and the next value of every registered output.
  // A command strobe is held once raised, so the command stays stable until the controller takes it.
  always_comb begin
    state_n      = state_q;
    resp_valid_n = 1'b0;
    resp_rdata_n = resp_rdata;
    dram_ren_n   = dram_ren;
    dram_wen_n   = dram_wen;
    dram_addr_n  = dram_addr;
    dram_wdata_n = dram_wdata;
    dram_wmask_n = dram_wmask;

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_wen) begin
            state_n      = WR_CMD;
            dram_wen_n   = dram_init_calib_complete;
            dram_addr_n  = req_line_addr;
            dram_wdata_n = {4{req_wdata}};
            dram_wmask_n = ~(APP_MASK_WIDTH'(req_wstrb) << {req_lane, 2'b00});
          end else if (buf_hit) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_rdata_n = buf_data[{req_lane, 5'b00000} +: 32];
          end else begin
            state_n     = RD_CMD;
            dram_ren_n  = dram_init_calib_complete;
            dram_addr_n = req_line_addr;
          end
        end
      end

      RD_CMD: begin
        if (dram_ren && !dram_busy) begin
          state_n    = RD_WAIT;
          dram_ren_n = 1'b0;
        end else begin
          dram_ren_n = dram_ren || dram_init_calib_complete;
        end
      end

      RD_WAIT: begin
        if (dram_rdata_valid) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = dram_rdata[{lat_lane, 5'b00000} +: 32];
        end
      end

      WR_CMD: begin
        if (dram_wen && !dram_busy) begin
          state_n      = RESP;
          dram_wen_n   = 1'b0;
          resp_valid_n = 1'b1;
          resp_rdata_n = 32'h0000_0000;
        end else begin
          dram_wen_n = dram_wen || dram_init_calib_complete;
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    req_ready_n = (state_n == IDLE);
  end

  // Register the state and all outputs. Reset abandons any transaction without a response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      dram_ren   <= 1'b0;
      dram_wen   <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wmask <= '1;
    end else begin
      state_q    <= state_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      dram_ren   <= dram_ren_n;
      dram_wen   <= dram_wen_n;
      dram_addr  <= dram_addr_n;
      dram_wdata <= dram_wdata_n;
      dram_wmask <= dram_wmask_n;
    end
  end

  // Track the outstanding miss, fill the buffer on a line return, and keep the buffer coherent with writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      lat_tag   <= '0;
      lat_lane  <= '0;
    end else begin
      if (req_fire && (req_wen || !buf_hit)) begin
        lat_tag  <= req_tag;
        lat_lane <= req_lane;
      end
      if (req_fire && req_wen && buf_hit) begin
        buf_data <= buf_merged;
      end
      if ((state_q == RD_WAIT) && dram_rdata_valid) begin
        buf_data  <= dram_rdata;
        buf_tag   <= lat_tag;
        buf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_word_bridge.sv
// tb_dram_word_bridge
// Directed bench for dram_word_bridge. A small DRAM responder returns lines
// after a configurable latency. Expected read data is queued when each request
// is driven, and is compared when the bridge raises resp_valid.
module tb_dram_word_bridge;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_wen;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_wstrb;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         dram_ren;
  logic         dram_wen;
  logic [26:0]  dram_addr;
  logic [127:0] dram_wdata;
  logic [15:0]  dram_wmask;
  logic         dram_init_calib_complete;
  logic         dram_busy;
  logic [127:0] dram_rdata = '0;
  logic         dram_rdata_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  int          resp_seen = 0;

  int          rd_cmds = 0;
  int          wr_cmds = 0;
  int          rd_latency = 3;
  logic        rd_pending = 1'b0;
  int          rd_countdown = 0;
  logic [26:0] rd_addr_seen = '0;

  always #5 clock = ~clock;

  dram_word_bridge dut (
    .clock                    (clock),
    .reset                    (reset),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .req_wen                  (req_wen),
    .req_addr                 (req_addr),
    .req_wdata                (req_wdata),
    .req_wstrb                (req_wstrb),
    .resp_valid               (resp_valid),
    .resp_rdata               (resp_rdata),
    .dram_ren                 (dram_ren),
    .dram_wen                 (dram_wen),
    .dram_addr                (dram_addr),
    .dram_wdata               (dram_wdata),
    .dram_wmask               (dram_wmask),
    .dram_init_calib_complete (dram_init_calib_complete),
    .dram_busy                (dram_busy),
    .dram_rdata               (dram_rdata),
    .dram_rdata_valid         (dram_rdata_valid)
  );

  // DRAM contents. Line address 8 holds the test-plan pattern; every other
  // line holds 0xD000_0000 | (line_addr << 4) | lane.
  function automatic logic [127:0] line_data(input logic [26:0] a);
    logic [127:0] d;
    if (a == 27'h000008) begin
      d = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    end else begin
      for (int k = 0; k < 4; k++) begin
        d[32 * k +: 32] = 32'hD000_0000 | (32'(a) << 4) | 32'(k);
      end
    end
    return d;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Count command transfers the way the controller sees them, and schedule a line return for each read.
  always @(posedge clock) begin
    if (!reset && dram_ren && !dram_busy) begin
      rd_cmds++;
      rd_pending   = 1'b1;
      rd_countdown = rd_latency;
      rd_addr_seen = dram_addr;
    end
    if (!reset && dram_wen && !dram_busy) begin
      wr_cmds++;
    end
  end

  // Drive the scheduled line return for one cycle. The return is made even across a bridge reset.
  always @(negedge clock) begin
    dram_rdata_valid = 1'b0;
    if (rd_pending) begin
      if (rd_countdown == 0) begin
        dram_rdata_valid = 1'b1;
        dram_rdata       = line_data(rd_addr_seen);
        rd_pending       = 1'b0;
      end else begin
        rd_countdown--;
      end
    end
  end

  // Scoreboard: every response must match the oldest queued expectation, and the two command strobes must never overlap.
  always @(negedge clock) begin
    if (!reset) begin
      check_output("ren_wen_exclusive", 128'(dram_ren && dram_wen), 128'(0));
      if (resp_valid) begin
        resp_seen++;
        check_output("resp_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check_output("resp_rdata", 128'(resp_rdata), 128'(exp_word));
        end
      end
    end
  end

  // Present one request at a negedge, queue its expected data, and drop it after the accepting edge.
  task automatic apply_stimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] expected);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_output("req_ready_wait", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    exp_q.push_back(expected);
    @(negedge clock);
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  // Wait for resp_valid. The first negedge after acceptance counts as 1.
  task automatic wait_resp(output int cycles);
    cycles = 1;
    while (!resp_valid && cycles < 200) begin
      @(negedge clock);
      cycles++;
    end
    check_output("resp_timeout", 128'(resp_valid), 128'(1));
  endtask

  // Directed sequence.
  initial begin
    int lat;
    int base;
    int ren_high;
    int n;
    int resp_before;

    reset                    = 1'b1;
    req_valid                = 1'b0;
    req_wen                  = 1'b0;
    req_addr                 = '0;
    req_wdata                = '0;
    req_wstrb                = '0;
    dram_init_calib_complete = 1'b0;
    dram_busy                = 1'b0;

    repeat (3) @(negedge clock);
    check_output("rst_resp_valid", 128'(resp_valid), 128'(0));
    check_output("rst_dram_ren", 128'(dram_ren), 128'(0));
    check_output("rst_dram_wmask", 128'(dram_wmask), 128'(16'hFFFF));
    reset = 1'b0;
    @(negedge clock);
    check_output("post_rst_req_ready", 128'(req_ready), 128'(1));
    check_output("post_rst_resp_valid", 128'(resp_valid), 128'(0));
    check_output("post_rst_dram_ren", 128'(dram_ren), 128'(0));
    check_output("post_rst_dram_wen", 128'(dram_wen), 128'(0));
    check_output("post_rst_resp_rdata", 128'(resp_rdata), 128'(0));
    check_output("post_rst_dram_addr", 128'(dram_addr), 128'(0));
    check_output("post_rst_dram_wdata", dram_wdata, 128'(0));
    check_output("post_rst_dram_wmask", 128'(dram_wmask), 128'(16'hFFFF));

    $display("[TB] read miss 0x10 with calibration held low");
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1111_1111);
    ren_high = 0;
    repeat (20) begin
      if (dram_ren) ren_high++;
      @(negedge clock);
    end
    check_output("no_ren_before_calib", 128'(ren_high), 128'(0));
    dram_init_calib_complete = 1'b1;
    n = 0;
    while (!dram_ren && n < 10) begin
      @(negedge clock);
      n++;
    end
    check_output("ren_after_calib", 128'(dram_ren), 128'(1));
    check_output("miss_addr_0x10", 128'(dram_addr), 128'(27'h000008));
    wait_resp(lat);
    check_output("miss_cmds_0x10", 128'(rd_cmds - base), 128'(1));

    $display("[TB] read hits 0x14 and 0x18");
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h2222_2222);
    wait_resp(lat);
    check_output("hit_latency_0x14", 128'(lat), 128'(1));
    check_output("hit_ready_low", 128'(req_ready), 128'(0));
    @(negedge clock);
    check_output("hit_ready_back", 128'(req_ready), 128'(1));
    apply_stimulus(1'b0, 32'h0000_0018, 32'h0, 4'h0, 32'h3333_3333);
    wait_resp(lat);
    check_output("hit_latency_0x18", 128'(lat), 128'(1));
    check_output("hit_no_dram_cmd", 128'(rd_cmds - base), 128'(0));

    $display("[TB] write 0x1C with partial strobe, then read it back");
    base = wr_cmds;
    apply_stimulus(1'b1, 32'h0000_001C, 32'hAABB_CCDD, 4'b0011, 32'h0000_0000);
    check_output("wr_wen", 128'(dram_wen), 128'(1));
    check_output("wr_no_ren", 128'(dram_ren), 128'(0));
    check_output("wr_addr", 128'(dram_addr), 128'(27'h000008));
    check_output("wr_wmask", 128'(dram_wmask), 128'(16'hCFFF));
    check_output("wr_wdata", dram_wdata, {4{32'hAABB_CCDD}});
    wait_resp(lat);
    check_output("wr_latency", 128'(lat), 128'(2));
    check_output("wr_cmd_count", 128'(wr_cmds - base), 128'(1));
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_001C, 32'h0, 4'h0, 32'h4444_CCDD);
    wait_resp(lat);
    check_output("hit_after_write_latency", 128'(lat), 128'(1));
    check_output("hit_after_write_no_cmd", 128'(rd_cmds - base), 128'(0));

    $display("[TB] miss 0x44 with dram_busy held for five cycles");
    dram_busy = 1'b1;
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'hD000_0201);
    repeat (5) begin
      check_output("busy_ren_hold", 128'(dram_ren), 128'(1));
      check_output("busy_addr_hold", 128'(dram_addr), 128'(27'h000020));
      @(negedge clock);
    end
    dram_busy = 1'b0;
    @(negedge clock);
    check_output("ren_drop_after_accept", 128'(dram_ren), 128'(0));
    wait_resp(lat);
    check_output("busy_single_cmd", 128'(rd_cmds - base), 128'(1));

    $display("[TB] reset while waiting for read data");
    rd_latency = 6;
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'hDEAD_BEEF);
    @(negedge clock);
    check_output("rd_wait_cmd_sent", 128'(rd_cmds - base), 128'(1));
    reset = 1'b1;
    exp_q.delete();
    resp_before = resp_seen;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check_output("no_resp_after_reset", 128'(resp_seen - resp_before), 128'(0));
    rd_latency = 3;
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'hD000_0400);
    check_output("miss_after_reset_ren", 128'(dram_ren), 128'(1));
    wait_resp(lat);
    check_output("miss_after_reset_cmd", 128'(rd_cmds - base), 128'(1));

    $display("[TB] line replacement 0x10 -> 0x20");
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1111_1111);
    wait_resp(lat);
    check_output("refill_0x10_miss", 128'(rd_cmds - base), 128'(1));
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hD000_0100);
    check_output("miss_addr_0x20", 128'(dram_addr), 128'(27'h000010));
    wait_resp(lat);
    check_output("miss_0x20_cmd", 128'(rd_cmds - base), 128'(1));
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'hD000_0101);
    wait_resp(lat);
    check_output("hit_0x24_latency", 128'(lat), 128'(1));
    check_output("hit_0x24_no_cmd", 128'(rd_cmds - base), 128'(0));
    base = rd_cmds;
    apply_stimulus(1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h2222_2222);
    wait_resp(lat);
    check_output("old_line_evicted", 128'(rd_cmds - base), 128'(1));

    @(negedge clock);
    check_output("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
